// File: rtl/network_bram_sequencer.sv
// network_bram_sequencer: start/done BRAM transfer engine between one SNN core/LIF tile and the parameter BRAM.
// Define NETWORK_BRAM_SPIKE_SKIP_EN to skip weight rows of presynaptic neurons that did not spike.
module network_bram_sequencer #(
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int WIDTH            = 8,
    parameter int NEURONS_PER_CORE = 4,
    parameter int MAX_TILES        = 16,
    parameter int MAX_NEURONS      = 16,
    parameter int READ_LATENCY     = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start,
    input  logic [1:0]                                           mode,
    input  logic [$clog2(MAX_TILES+1)-1:0]                       tile_idx,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 err,
    output logic [BRAM_ADDR_WIDTH-1:0]                           bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]                           bram_din,
    input  logic [BRAM_DATA_WIDTH-1:0]                           bram_dout,
    output logic                                                 bram_en,
    output logic [BRAM_DATA_WIDTH/WIDTH-1:0]                     bram_we,
    input  logic [NEURONS_PER_CORE*WIDTH-1:0]                    mem_in,
    input  logic [NEURONS_PER_CORE-1:0]                          spk_out,
    output logic [NEURONS_PER_CORE*NEURONS_PER_CORE*WIDTH-1:0]   weight,
    output logic [NEURONS_PER_CORE*WIDTH-1:0]                    mem_out,
    output logic [NEURONS_PER_CORE*WIDTH-1:0]                    network_input,
    output logic [NEURONS_PER_CORE-1:0]                          spk_in,
    output logic [WIDTH-1:0]                                     core_idx_x,
    output logic [WIDTH-1:0]                                     core_idx_y,
    output logic                                                 snn_en,
    output logic                                                 snn_rst
);
    localparam int BAW        = BRAM_ADDR_WIDTH;
    localparam int BDW        = BRAM_DATA_WIDTH;
    localparam int LANES      = BDW / WIDTH;
    localparam int N          = NEURONS_PER_CORE;
    localparam int V          = N / LANES;
    localparam int TW         = $clog2(MAX_TILES + 1);
    localparam int TILE_WORDS = 1 + N * V;
    localparam int IN_OFF     = TILE_WORDS * MAX_TILES;
    localparam int SPK_OFF    = IN_OFF + MAX_NEURONS / LANES;
    localparam int FLAG_OFF   = SPK_OFF + MAX_NEURONS / LANES;
    localparam int MEM_OFF    = FLAG_OFF + 1;
    localparam int T_TILE     = 1 + 2 * V + N * V;
    localparam int IW         = $clog2(T_TILE + V + 1);
    localparam int RW         = N > 1 ? $clog2(N) : 1;
    localparam int WCW        = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;
    typedef enum logic [2:0] {D_HDR, D_MEM, D_SPK, D_WGT, D_IN, D_FLAG, D_WSPK, D_WMEM} dst_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic [TW-1:0]      tile_q;
    logic [IW-1:0]      idx_q, idx_nxt, k, total;
    logic [WCW-1:0]     wcnt_q;
    logic               err_q, snn_en_q, snn_rst_q;
    logic [N*N*WIDTH-1:0] weight_q;
    logic [N*WIDTH-1:0] mem_out_q, net_in_q;
    logic [N-1:0]       spk_in_q;
    logic [WIDTH-1:0]   cx_q, cy_q;
    dst_t               dst;
    logic [BAW-1:0]     addr, tile_base, tile_vec;
    logic [BDW-1:0]     din;
    logic [RW-1:0]      row;
    logic               skip, wr, seq_end, illegal;

    assign tile_base = BAW'(tile_q) * BAW'(TILE_WORDS);
    assign tile_vec  = BAW'(tile_q) * BAW'(V);
    assign illegal   = tile_q >= TW'(MAX_TILES);

    // Decode the current word index of the active mode into destination, vector word and address
    always_comb begin
        dst = D_HDR;
        k = '0;
        addr = tile_base;
        total = IW'(T_TILE);
        case (mode_q)
            2'd0: begin
                if (idx_q == '0) dst = D_HDR;
                else if (idx_q <= IW'(V)) begin
                    dst = D_MEM;
                    k = idx_q - IW'(1);
                    addr = BAW'(MEM_OFF) + BAW'(cy_q) * BAW'(V) + BAW'(k);
                end else if (idx_q <= IW'(2 * V)) begin
                    dst = D_SPK;
                    k = idx_q - IW'(V + 1);
                    addr = BAW'(SPK_OFF) + BAW'(cx_q) * BAW'(V) + BAW'(k);
                end else begin
                    dst = D_WGT;
                    k = idx_q - IW'(2 * V + 1);
                    addr = tile_base + BAW'(1) + BAW'(k);
                end
            end
            2'd1: begin
                total = IW'(V);
                dst = D_WMEM;
                k = idx_q;
                addr = BAW'(MEM_OFF) + tile_vec + BAW'(k);
            end
            2'd2: begin
                total = IW'(2 * V + 1);
                if (idx_q < IW'(V)) begin
                    dst = D_IN;
                    k = idx_q;
                    addr = BAW'(IN_OFF) + tile_vec + BAW'(k);
                end else if (idx_q < IW'(2 * V)) begin
                    dst = D_MEM;
                    k = idx_q - IW'(V);
                    addr = BAW'(MEM_OFF) + tile_vec + BAW'(k);
                end else begin
                    dst = D_FLAG;
                    addr = BAW'(FLAG_OFF);
                end
            end
            default: begin
                total = IW'(2 * V);
                if (idx_q < IW'(V)) begin
                    dst = D_WSPK;
                    k = idx_q;
                    addr = BAW'(SPK_OFF) + tile_vec + BAW'(k);
                end else begin
                    dst = D_WMEM;
                    k = idx_q - IW'(V);
                    addr = BAW'(MEM_OFF) + tile_vec + BAW'(k);
                end
            end
        endcase
    end

    assign row = RW'(k / IW'(V));
`ifdef NETWORK_BRAM_SPIKE_SKIP_EN
    assign skip = (dst == D_WGT) && !spk_in_q[row];
`else
    assign skip = 1'b0;
`endif
    assign wr      = (dst == D_WSPK) || (dst == D_WMEM);
    assign idx_nxt = idx_q + (skip ? IW'(V) : IW'(1));
    assign seq_end = idx_nxt >= total;

    always_comb begin
        din = '0;
        for (int j = 0; j < V; j++)
            if (k == IW'(j))
                for (int i = 0; i < LANES; i++)
                    din[i*WIDTH +: WIDTH] = dst == D_WSPK ? WIDTH'(spk_out[j*LANES+i])
                                                          : mem_in[(j*LANES+i)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = start ? S_CHECK : S_IDLE;
            S_CHECK:   state_d = illegal ? S_DONE : S_ISSUE;
            S_ISSUE:   state_d = (skip || wr) ? (seq_end ? S_DONE : S_ISSUE)
                                              : (READ_LATENCY > 1 ? S_WAIT : S_CAPTURE);
            S_WAIT:    state_d = int'(wcnt_q) >= READ_LATENCY - 2 ? S_CAPTURE : S_WAIT;
            S_CAPTURE: state_d = seq_end ? S_DONE : S_ISSUE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q inside {S_CHECK, S_ISSUE, S_WAIT, S_CAPTURE};
        done      = state_q == S_DONE;
        bram_en   = (state_q == S_ISSUE) && !skip;
        bram_we   = bram_en && wr ? '1 : '0;
        bram_addr = bram_en ? addr : '0;
        bram_din  = bram_en && wr ? din : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            tile_q    <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
            weight_q  <= '0;
            mem_out_q <= '0;
            net_in_q  <= '0;
            spk_in_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            snn_en_q  <= 1'b0;
            snn_rst_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                mode_q <= mode;
                tile_q <= tile_idx;
                idx_q  <= '0;
                err_q  <= 1'b0;
            end
            if (state_q == S_CHECK) err_q <= illegal;
            wcnt_q <= state_q == S_WAIT ? wcnt_q + 1'b1 : '0;
            if (state_q == S_CAPTURE || (state_q == S_ISSUE && (skip || wr))) idx_q <= idx_nxt;
            if (state_q == S_ISSUE && skip)
                for (int r = 0; r < N; r++)
                    if (row == RW'(r)) weight_q[r*N*WIDTH +: N*WIDTH] <= '0;
            if (state_q == S_CAPTURE)
                case (dst)
                    D_HDR: begin
                        cy_q <= bram_dout[WIDTH-1:0];
                        cx_q <= bram_dout[2*WIDTH-1:WIDTH];
                    end
                    D_FLAG: begin
                        snn_en_q  <= bram_dout[0];
                        snn_rst_q <= bram_dout[2];
                    end
                    D_WGT: for (int j = 0; j < N * V; j++) if (k == IW'(j)) weight_q[j*BDW +: BDW] <= bram_dout;
                    D_MEM: for (int j = 0; j < V; j++) if (k == IW'(j)) mem_out_q[j*BDW +: BDW] <= bram_dout;
                    D_IN:  for (int j = 0; j < V; j++) if (k == IW'(j)) net_in_q[j*BDW +: BDW] <= bram_dout;
                    D_SPK:
                        for (int j = 0; j < V; j++)
                            if (k == IW'(j))
                                for (int i = 0; i < LANES; i++) spk_in_q[j*LANES+i] <= bram_dout[i*WIDTH];
                    default: ;
                endcase
        end
    end

    assign err           = err_q;
    assign weight        = weight_q;
    assign mem_out       = mem_out_q;
    assign network_input = net_in_q;
    assign spk_in        = spk_in_q;
    assign core_idx_x    = cx_q;
    assign core_idx_y    = cy_q;
    assign snn_en        = snn_en_q;
    assign snn_rst       = snn_rst_q;
endmodule

// File: tb/tb_network_bram_sequencer.sv
// tb_network_bram_sequencer: directed bench for network_bram_sequencer with a two-stage-latency BRAM model.
module tb_network_bram_sequencer;
    logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [1:0]   mode = '0;
    logic [4:0]   tile_idx = '0;
    logic         busy, done, err, bram_en, snn_en, snn_rst;
    logic [9:0]   bram_addr;
    logic [31:0]  bram_din, mem_out, network_input;
    logic [31:0]  bram_dout = '0, rd1 = '0, mem_in = '0;
    logic [3:0]   bram_we, spk_in, spk_out = '0;
    logic [127:0] weight;
    logic [7:0]   core_idx_x, core_idx_y;
    logic [31:0]  bram [0:1023];
    logic         seen [0:1023];
    int           checks = 0, errors = 0, lat, ens;
    int           order[$];
    logic [3:0]   wes[$];

    always #5 clk = ~clk;

    network_bram_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .tile_idx(tile_idx),
        .busy(busy), .done(done), .err(err), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .bram_en(bram_en), .bram_we(bram_we), .mem_in(mem_in),
        .spk_out(spk_out), .weight(weight), .mem_out(mem_out), .network_input(network_input),
        .spk_in(spk_in), .core_idx_x(core_idx_x), .core_idx_y(core_idx_y),
        .snn_en(snn_en), .snn_rst(snn_rst)
    );

    // READ_LATENCY=2: data addressed in ISSUE is on bram_dout during CAPTURE
    always @(posedge clk) begin
        if (bram_en && bram_we == 4'h0) rd1 <= bram[bram_addr];
        bram_dout <= rd1;
        if (bram_en)
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [4:0] t);
        lat = -1;
        ens = 0;
        order = {};
        wes = {};
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        tile_idx = t;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (bram_en) begin
                ens++;
                seen[bram_addr] = 1'b1;
                order.push_back(int'(bram_addr));
                wes.push_back(bram_we);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bram[i] = '0;
        bram[10] = 32'h0000_0103;
        bram[92] = 32'h0102_0304;
        bram[85] = 32'h0001_0001;
        bram[11] = 32'h1112_1314;
        bram[12] = 32'h2122_2324;
        bram[13] = 32'h3132_3334;
        bram[14] = 32'h4142_4344;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {busy, done, err, bram_en, bram_we, snn_en, snn_rst}, 0);
        check("rst_bus", {bram_addr, bram_din}, 0);
        check("rst_weight", weight, 0);
        check("rst_regs", {mem_out, network_input, spk_in, core_idx_x, core_idx_y}, 0);
        rst_n = 1'b1;

        run(2'd0, 5'd2);
        check("tile_x", core_idx_x, 8'd1);
        check("tile_y", core_idx_y, 8'd3);
        check("tile_mem", mem_out, 32'h0102_0304);
        check("tile_spk", spk_in, 4'b0101);
        check("tile_order", {order[0], order[1], order[2]}, {32'd10, 32'd92, 32'd85});
        check("tile_busy_at_done", busy, 1'b0);
`ifdef NETWORK_BRAM_SPIKE_SKIP_EN
        check("tile_lat", lat, 19);
        check("tile_ens", ens, 5);
        check("tile_weight", weight, {32'h0, 32'h3132_3334, 32'h0, 32'h1112_1314});
        check("tile_rows_read", {seen[12], seen[14]}, 2'b00);
`else
        check("tile_lat", lat, 23);
        check("tile_ens", ens, 7);
        check("tile_weight", weight, {32'h4142_4344, 32'h3132_3334, 32'h2122_2324, 32'h1112_1314});
        check("tile_rows_read", {seen[12], seen[14]}, 2'b11);
`endif
        @(negedge clk);
        check("done_pulse", done, 1'b0);

        spk_out = 4'b1001;
        mem_in = 32'hFF05_0007;
        run(2'd3, 5'd1);
        check("slif_lat", lat, 4);
        check("slif_ens", ens, 2);
        check("slif_we", {wes[0], wes[1]}, 8'hFF);
        check("slif_spk_word", bram[85], 32'h0100_0001);
        check("slif_mem_word", bram[90], 32'hFF05_0007);
        check("slif_hold", mem_out, 32'h0102_0304);

        bram[83] = 32'hAABB_CCDD;
        bram[92] = 32'h1122_3344;
        bram[88] = 32'h0000_0005;
        run(2'd2, 5'd3);
        check("llif_lat", lat, 11);
        check("llif_order", {order[0], order[1], order[2]}, {32'd83, 32'd92, 32'd88});
        check("llif_in", network_input, 32'hAABB_CCDD);
        check("llif_mem", mem_out, 32'h1122_3344);
        check("llif_flags", {snn_en, snn_rst}, 2'b11);

        mem_in = 32'h0A0B_0C0D;
        run(2'd1, 5'd4);
        check("smem_lat", lat, 3);
        check("smem_word", bram[93], 32'h0A0B_0C0D);

        run(2'd0, 5'd16);
        check("bad_lat", lat, 2);
        check("bad_err", err, 1'b1);
        check("bad_ens", ens, 0);
        @(negedge clk);
        check("bad_err_hold", {err, done}, 2'b10);
        run(2'd1, 5'd0);
        check("good_lat", lat, 3);
        check("good_err", err, 1'b0);
        check("good_word", bram[89], 32'h0A0B_0C0D);

        @(negedge clk);
        start = 1'b1;
        mode = 2'd2;
        tile_idx = 5'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_issue_en", bram_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {busy, done, err, bram_en, bram_we, snn_en, snn_rst, bram_addr, bram_din}, 0);
        check("mid_rst_regs", {mem_out, network_input, spk_in, core_idx_x, core_idx_y}, 0);
        check("mid_rst_weight", weight, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {busy, bram_en}, 2'b00);
        run(2'd2, 5'd3);
        check("post_rst_lat", lat, 11);
        check("post_rst_in", network_input, 32'hAABB_CCDD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
